// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: buffers the line-draw pixel stream in a small FIFO, culls
// off-screen pixels, and issues one framebuffer write per on-screen pixel over
// a req/ack handshake. Writes issue strictly in acceptance order.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pix_valid_i/pix_ready_o  input pixel handshake (ready depends only on state and rst)
//   x_i, y_i, r_i, g_i, b_i  pixel position and colour
//   mem_req_o, mem_ack_i     framebuffer write handshake
//   mem_addr_o, mem_data_o   write address (BASE_ADDR + y*FB_WIDTH + x) and {r,g,b}
//   fifo_empty_o             writer idle: FIFO empty and no request outstanding
//   drop_count_o             saturating count of culled pixels
module gpu_pixel_writer #(
  parameter int unsigned FB_WIDTH   = 640,
  parameter int unsigned FB_HEIGHT  = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [10:0]       x_i,
  input  logic [9:0]        y_i,
  input  logic [7:0]        r_i,
  input  logic [7:0]        g_i,
  input  logic [7:0]        b_i,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       mem_data_o,
  output logic              fifo_empty_o,
  output logic [15:0]       drop_count_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned DATA_W = 24;

  typedef logic [PTR_W:0] ptr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state, next_state;
  entry_t            fifo_mem [FIFO_DEPTH];
  ptr_t              wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty;
  logic              on_screen, accept, push, drop, pop;
  logic [ADDR_W-1:0] addr_calc;
  entry_t            push_entry, head_entry;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pix_ready_o  = !rst && !fifo_full;
  assign fifo_empty_o = fifo_empty && (state == IDLE);

  // Address is taken modulo 2^ADDR_W; mod arithmetic makes ADDR_W-bit
  // multiply/add give the same truncated result as a wider intermediate.
  assign addr_calc = ADDR_W'(y_i) * ADDR_W'(FB_WIDTH) + ADDR_W'(x_i) + ADDR_W'(BASE_ADDR);

  assign on_screen  = (32'(x_i) < FB_WIDTH) && (32'(y_i) < FB_HEIGHT);
  assign accept     = pix_valid_i && pix_ready_o;
  assign push       = accept && on_screen;
  assign drop       = accept && !on_screen;
  assign push_entry = '{addr: addr_calc, data: {r_i, g_i, b_i}};
  assign head_entry = fifo_mem[rd_ptr[PTR_W-1:0]];

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Saturating culled-pixel counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_o <= '0;
    end else if (drop && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end

  // Next-state and pop decision; pop only sees entries pushed on earlier edges.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state     <= next_state;
      mem_req_o <= (next_state == REQ);
      if (pop) begin
        mem_addr_o <= head_entry.addr;
        mem_data_o <= head_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer: reset, single-pixel address/culling
// vectors, backpressure with in-order draining, drop-count saturation, and
// reset in the middle of an outstanding request.
module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready, pix_ready_b;
  logic [10:0] x;
  logic [9:0]  y;
  logic [7:0]  r, g, b;
  logic        mem_req, mem_req_b;
  logic        mem_ack;
  logic [18:0] mem_addr, mem_addr_b;
  logic [23:0] mem_data, mem_data_b;
  logic        fifo_empty, fifo_empty_b;
  logic [15:0] drop_count, drop_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpu_pixel_writer dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .x_i(x), .y_i(y), .r_i(r), .g_i(g), .b_i(b),
    .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .fifo_empty_o(fifo_empty), .drop_count_o(drop_count)
  );

  gpu_pixel_writer #(.BASE_ADDR(1000)) dut_b (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready_b),
    .x_i(x), .y_i(y), .r_i(r), .g_i(g), .b_i(b),
    .mem_req_o(mem_req_b), .mem_ack_i(mem_ack), .mem_addr_o(mem_addr_b),
    .mem_data_o(mem_data_b), .fifo_empty_o(fifo_empty_b), .drop_count_o(drop_count_b)
  );

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        cull;
    logic [18:0] addr;    // BASE_ADDR = 0
    logic [18:0] addr_b;  // BASE_ADDR = 1000
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_pix(input logic [10:0] px, input logic [9:0] py, input logic [23:0] rgb);
    x = px;
    y = py;
    {r, g, b} = rgb;
    pix_valid = 1'b1;
  endtask

  logic [18:0] bp_addr [9];
  logic [23:0] bp_data [9];
  logic [15:0] exp_drop;
  int          accepted;
  int          stale_reqs;
  logic        rdy;

  initial begin
    vecs[0] = '{x: 11'd5,    y: 10'd2,    rgb: 24'hFF8001, cull: 1'b0, addr: 19'd1285,   addr_b: 19'd2285};
    vecs[1] = '{x: 11'd639,  y: 10'd479,  rgb: 24'h112233, cull: 1'b0, addr: 19'd307199, addr_b: 19'd308199};
    vecs[2] = '{x: 11'd0,    y: 10'd0,    rgb: 24'h000001, cull: 1'b0, addr: 19'd0,      addr_b: 19'd1000};
    vecs[3] = '{x: 11'd640,  y: 10'd0,    rgb: 24'hAAAAAA, cull: 1'b1, addr: 19'd0,      addr_b: 19'd0};
    vecs[4] = '{x: 11'd0,    y: 10'd480,  rgb: 24'hBBBBBB, cull: 1'b1, addr: 19'd0,      addr_b: 19'd0};
    vecs[5] = '{x: 11'd2047, y: 10'd1023, rgb: 24'hCCCCCC, cull: 1'b1, addr: 19'd0,      addr_b: 19'd0};
    vecs[6] = '{x: 11'd100,  y: 10'd300,  rgb: 24'h123456, cull: 1'b0, addr: 19'd192100, addr_b: 19'd193100};
    vecs[7] = '{x: 11'd639,  y: 10'd0,    rgb: 24'h0A0B0C, cull: 1'b0, addr: 19'd639,    addr_b: 19'd1639};
    vecs[8] = '{x: 11'd0,    y: 10'd479,  rgb: 24'hFEDCBA, cull: 1'b0, addr: 19'd306560, addr_b: 19'd307560};

    rst = 1'b1; pix_valid = 1'b0; mem_ack = 1'b0;
    x = '0; y = '0; r = '0; g = '0; b = '0;
    exp_drop = 16'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_data",  32'(mem_data), 32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_ready", 32'(pix_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(pix_ready), 32'd1);

    // Single-pixel vectors with ack tied high.
    mem_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_pix(vecs[i].x, vecs[i].y, vecs[i].rgb);
      @(posedge clk);
      @(negedge clk);
      pix_valid = 1'b0;
      if (vecs[i].cull) begin
        exp_drop = exp_drop + 16'd1;
        chk($sformatf("v%0d_cull_req", i),   32'(mem_req), 32'd0);
        chk($sformatf("v%0d_cull_ready", i), 32'(pix_ready), 32'd1);
        chk($sformatf("v%0d_cull_drop", i),  32'(drop_count), 32'(exp_drop));
        chk($sformatf("v%0d_cull_empty", i), 32'(fifo_empty), 32'd1);
      end else begin
        chk($sformatf("v%0d_lat_req", i),   32'(mem_req), 32'd0);
        chk($sformatf("v%0d_lat_empty", i), 32'(fifo_empty), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_req", i),    32'(mem_req), 32'd1);
        chk($sformatf("v%0d_addr", i),   32'(mem_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_addr_b", i), 32'(mem_addr_b), 32'(vecs[i].addr_b));
        chk($sformatf("v%0d_data", i),   32'(mem_data), 32'(vecs[i].rgb));
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_idle_req", i),   32'(mem_req), 32'd0);
        chk($sformatf("v%0d_idle_empty", i), 32'(fifo_empty), 32'd1);
      end
    end

    // Backpressure: 8 in FIFO plus 1 held in REQ, then in-order drain.
    mem_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bp_addr[k] = 19'((k * 640) + (k + 1));
      bp_data[k] = {8'(k), 8'hA5, ~8'(k)};
    end
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (accepted < 9) drive_pix(11'(accepted + 1), 10'(accepted), bp_data[accepted]);
      else              drive_pix(11'd33, 10'd33, 24'h333333);
      rdy = pix_ready;
      @(posedge clk);
      if (rdy) accepted++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("bp_accepted", 32'(accepted), 32'd9);
    chk("bp_ready",    32'(pix_ready), 32'd0);
    chk("bp_req",      32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("bp%0d_req", k),  32'(mem_req), 32'd1);
      chk($sformatf("bp%0d_addr", k), 32'(mem_addr), 32'(bp_addr[k]));
      chk($sformatf("bp%0d_data", k), 32'(mem_data), 32'(bp_data[k]));
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_done_req",   32'(mem_req), 32'd0);
    chk("bp_done_empty", 32'(fifo_empty), 32'd1);

    // Drop counter saturation (exp_drop is 3 here).
    drive_pix(11'd2047, 10'd1023, 24'h0);
    repeat (int'(16'hFFFE - exp_drop)) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", 32'(drop_count), 32'h0000FFFE);
    @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", 32'(drop_count), 32'h0000FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    chk("sat_hold",  32'(drop_count), 32'h0000FFFF);
    chk("sat_req",   32'(mem_req), 32'd0);
    chk("sat_ready", 32'(pix_ready), 32'd1);

    // Reset while a request is outstanding with 4 queued behind it.
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_pix(11'(10 + k), 10'(20 + k), 24'h00FF00);
      @(posedge clk);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk("mid_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_req_async", 32'(mem_req), 32'd0);
    chk("mid_empty",     32'(fifo_empty), 32'd1);
    chk("mid_ready",     32'(pix_ready), 32'd0);
    chk("mid_drop",      32'(drop_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    stale_reqs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req) stale_reqs++;
    end
    chk("mid_stale", 32'(stale_reqs), 32'd0);
    drive_pix(11'd7, 10'd3, 24'hC0FFEE);
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_new_req",  32'(mem_req), 32'd1);
    chk("mid_new_addr", 32'(mem_addr), 32'd1927);
    chk("mid_new_data", 32'(mem_data), 32'h00C0FFEE);
    @(posedge clk);
    @(negedge clk);
    chk("mid_new_idle", 32'(fifo_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
